// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared control-bundle types and forwarding select codes
package pipe_ctrl_pkg;

   localparam int RF_AW_DEFAULT = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   // Field order matches the decoder's 10-bit control bundle, MSB first.
   typedef struct packed {
      logic [1:0] jump;
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic [1:0] alu_op;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // Newer producer (MEM) wins over older producer (WB).
   function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
      if (mem_hit)
         return FWD_MEM;
      else if (wb_hit)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// rtl/pipe_ctrl_hazard_unit.sv - combinational load-use stall, flush and EX forwarding selects
module hazard_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int RF_AW = RF_AW_DEFAULT
) (
   input  logic             id_valid,
   input  logic [RF_AW-1:0] id_rs1,
   input  logic [RF_AW-1:0] id_rs2,
   input  logic             ex_taken,
   input  logic             ex_valid,
   input  logic [1:0]       ex_jump,
   input  logic             ex_branch,
   input  logic             ex_mem_read,
   input  logic [RF_AW-1:0] ex_rs1,
   input  logic [RF_AW-1:0] ex_rs2,
   input  logic [RF_AW-1:0] ex_rd,
   input  logic             mem_valid,
   input  logic             mem_reg_write,
   input  logic [RF_AW-1:0] mem_rd,
   input  logic             wb_valid,
   input  logic             wb_reg_write,
   input  logic [RF_AW-1:0] wb_rd,
   output logic             load_use,
   output logic             stall,
   output logic             flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   logic mem_producer;
   logic wb_producer;

   // A taken indication only counts for a real control-transfer instruction in EX.
   assign flush = ex_taken & ex_valid & (ex_branch | (ex_jump != 2'b00));

   // rs2 is compared regardless of opcode; occasional false stalls on I-type are tolerated.
   assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   // The ID instruction is being squashed, so holding it would be pointless.
   assign stall = load_use & ~flush;

   assign mem_producer = mem_valid & mem_reg_write & (mem_rd != '0);
   assign wb_producer  = wb_valid & wb_reg_write & (wb_rd != '0);

   assign fwd_a = fwd_sel(mem_producer & (mem_rd == ex_rs1), wb_producer & (wb_rd == ex_rs1));
   assign fwd_b = fwd_sel(mem_producer & (mem_rd == ex_rs2), wb_producer & (wb_rd == ex_rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - ID/EX, EX/MEM, MEM/WB control stage registers plus hazard generation
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RF_AW = RF_AW_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [1:0]       id_jump,
   input  logic             id_branch,
   input  logic             id_mem_read,
   input  logic             id_mem_to_reg,
   input  logic [1:0]       id_alu_op,
   input  logic             id_mem_write,
   input  logic             id_alu_src,
   input  logic             id_reg_write,
   input  logic [RF_AW-1:0] id_rs1,
   input  logic [RF_AW-1:0] id_rs2,
   input  logic [RF_AW-1:0] id_rd,
   input  logic             ex_taken,
   output logic             ex_valid,
   output logic [1:0]       ex_jump,
   output logic             ex_branch,
   output logic             ex_mem_read,
   output logic             ex_mem_to_reg,
   output logic [1:0]       ex_alu_op,
   output logic             ex_mem_write,
   output logic             ex_alu_src,
   output logic             ex_reg_write,
   output logic [RF_AW-1:0] ex_rs1,
   output logic [RF_AW-1:0] ex_rs2,
   output logic [RF_AW-1:0] ex_rd,
   output logic             mem_valid,
   output logic             mem_mem_read,
   output logic             mem_mem_write,
   output logic             mem_mem_to_reg,
   output logic             mem_reg_write,
   output logic [RF_AW-1:0] mem_rd,
   output logic             wb_valid,
   output logic             wb_mem_to_reg,
   output logic             wb_reg_write,
   output logic [RF_AW-1:0] wb_rd,
   output logic             stall,
   output logic             flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   ctrl_t id_ctrl;
   ctrl_t ex_ctrl;
   logic  load_use;
   logic  ex_bubble;

   assign id_ctrl = '{
      jump:       id_jump,
      branch:     id_branch,
      mem_read:   id_mem_read,
      mem_to_reg: id_mem_to_reg,
      alu_op:     id_alu_op,
      mem_write:  id_mem_write,
      alu_src:    id_alu_src,
      reg_write:  id_reg_write
   };

   assign ex_jump       = ex_ctrl.jump;
   assign ex_branch     = ex_ctrl.branch;
   assign ex_mem_read   = ex_ctrl.mem_read;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign ex_alu_op     = ex_ctrl.alu_op;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_alu_src    = ex_ctrl.alu_src;
   assign ex_reg_write  = ex_ctrl.reg_write;

   // Squashed or load-use-held instructions leave a bubble behind in EX.
   assign ex_bubble = flush | load_use;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= CTRL_BUBBLE;
         ex_rs1   <= '0;
         ex_rs2   <= '0;
         ex_rd    <= '0;
      end else if (ex_bubble) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= CTRL_BUBBLE;
         ex_rs1   <= '0;
         ex_rs2   <= '0;
         ex_rd    <= '0;
      end else begin
         ex_valid <= id_valid;
         ex_ctrl  <= id_valid ? id_ctrl : CTRL_BUBBLE;
         ex_rs1   <= id_rs1;
         ex_rs2   <= id_rs2;
         ex_rd    <= id_rd;
      end
   end

   // EX/MEM and MEM/WB never stall: the load keeps moving while its consumer waits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid      <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_rd         <= '0;
      end else begin
         mem_valid      <= ex_valid;
         mem_mem_read   <= ex_ctrl.mem_read;
         mem_mem_write  <= ex_ctrl.mem_write;
         mem_mem_to_reg <= ex_ctrl.mem_to_reg;
         mem_reg_write  <= ex_ctrl.reg_write;
         mem_rd         <= ex_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid      <= 1'b0;
         wb_mem_to_reg <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_rd         <= '0;
      end else begin
         wb_valid      <= mem_valid;
         wb_mem_to_reg <= mem_mem_to_reg;
         wb_reg_write  <= mem_reg_write;
         wb_rd         <= mem_rd;
      end
   end

   hazard_unit #(
      .RF_AW (RF_AW)
   ) u_hazard (
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .ex_taken      (ex_taken),
      .ex_valid      (ex_valid),
      .ex_jump       (ex_ctrl.jump),
      .ex_branch     (ex_ctrl.branch),
      .ex_mem_read   (ex_ctrl.mem_read),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .ex_rd         (ex_rd),
      .mem_valid     (mem_valid),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .wb_valid      (wb_valid),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .load_use      (load_use),
      .stall         (stall),
      .flush         (flush),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

   localparam logic [9:0] C_ADD  = 10'b00_000_10_001;
   localparam logic [9:0] C_LW   = 10'b00_011_00_011;
   localparam logic [9:0] C_BRLD = 10'b00_110_00_000;
   localparam logic [9:0] C_NONE = 10'b00_000_00_000;

   typedef struct {
      logic       v;
      logic [9:0] c;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } instr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [1:0] id_jump = '0;
   logic       id_branch = 1'b0, id_mem_read = 1'b0, id_mem_to_reg = 1'b0;
   logic [1:0] id_alu_op = '0;
   logic       id_mem_write = 1'b0, id_alu_src = 1'b0, id_reg_write = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic       ex_taken = 1'b0;

   logic       ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
   logic [1:0] ex_jump, ex_alu_op;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic       mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
   logic [4:0] mem_rd;
   logic       wb_valid, wb_mem_to_reg, wb_reg_write;
   logic [4:0] wb_rd;
   logic       stall, flush;
   logic [1:0] fwd_a, fwd_b;

   int checks = 0;
   int errors = 0;

   instr_t cur, m_ex, m_mem, m_wb;
   logic   cur_taken;

   always #5 clk = ~clk;

   pipe_ctrl #(.RF_AW(5)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_jump(id_jump), .id_branch(id_branch), .id_mem_read(id_mem_read),
      .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op), .id_mem_write(id_mem_write),
      .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
      .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .ex_mem_write(ex_mem_write),
      .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic instr_t bubble();
      instr_t b;
      b.v = 1'b0; b.c = '0; b.rs1 = '0; b.rs2 = '0; b.rd = '0;
      return b;
   endfunction

   // Reference rules, computed directly from the instruction records.
   function automatic logic m_flush();
      return cur_taken && m_ex.v && (m_ex.c[7] || m_ex.c[9:8] != 2'b00);
   endfunction

   function automatic logic m_load_use();
      return m_ex.v && m_ex.c[6] && m_ex.rd != 0 && cur.v &&
             (m_ex.rd == cur.rs1 || m_ex.rd == cur.rs2);
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] src);
      if (m_mem.v && m_mem.c[0] && m_mem.rd != 0 && m_mem.rd == src) return 2'b10;
      if (m_wb.v && m_wb.c[0] && m_wb.rd != 0 && m_wb.rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [31:0] dut_ex();
      return {6'd0, ex_valid, ex_jump, ex_branch, ex_mem_read, ex_mem_to_reg, ex_alu_op,
              ex_mem_write, ex_alu_src, ex_reg_write, ex_rs1, ex_rs2, ex_rd};
   endfunction

   function automatic logic [31:0] dut_mem();
      return {22'd0, mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_rd};
   endfunction

   function automatic logic [31:0] dut_wb();
      return {24'd0, wb_valid, wb_mem_to_reg, wb_reg_write, wb_rd};
   endfunction

   function automatic logic [31:0] dut_haz();
      return {26'd0, stall, flush, fwd_a, fwd_b};
   endfunction

   task automatic set_in(input logic v, input logic [9:0] c, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic taken);
      cur.v = v; cur.c = c; cur.rs1 = rs1; cur.rs2 = rs2; cur.rd = rd; cur_taken = taken;
      id_valid = v;
      {id_jump, id_branch, id_mem_read, id_mem_to_reg, id_alu_op, id_mem_write, id_alu_src, id_reg_write} = c;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      ex_taken = taken;
   endtask

   task automatic eval();
      logic fl, lu;
      #1;
      fl = m_flush();
      lu = m_load_use();
      chk("ex_stage", dut_ex(), {6'd0, m_ex.v, m_ex.c, m_ex.rs1, m_ex.rs2, m_ex.rd});
      chk("mem_stage", dut_mem(), {22'd0, m_mem.v, m_mem.c[6], m_mem.c[2], m_mem.c[5], m_mem.c[0], m_mem.rd});
      chk("wb_stage", dut_wb(), {24'd0, m_wb.v, m_wb.c[5], m_wb.c[0], m_wb.rd});
      chk("hazards", dut_haz(), {26'd0, lu && !fl, fl, m_fwd(m_ex.rs1), m_fwd(m_ex.rs2)});
   endtask

   task automatic tick();
      instr_t nxt;
      logic   squash;
      squash = m_flush() || m_load_use();
      if (squash) nxt = bubble();
      else begin
         nxt = cur;
         if (!cur.v) nxt.c = '0;
      end
      @(posedge clk);
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = nxt;
      #1;
   endtask

   task automatic model_reset();
      m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
   endtask

   task automatic idle();
      set_in(1'b0, C_NONE, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   initial begin
      model_reset();
      idle();
      #3;
      chk("reset_all_zero", dut_ex() | dut_mem() | dut_wb() | dut_haz(), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      eval();

      // add x5 through the pipe: EX at 1, MEM at 2, WB at 3
      set_in(1'b1, C_ADD, 5'd1, 5'd2, 5'd5, 1'b0);
      eval(); tick();
      chk("add_ex_reg_write", {31'd0, ex_reg_write}, 32'd1);
      idle(); eval(); tick();
      chk("add_mem_rd", {27'd0, mem_rd}, 32'd5);
      eval(); tick();
      chk("add_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);

      // lw x5 ; add x6, x5, x1
      set_in(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 1'b0);
      eval(); tick();
      set_in(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 1'b0);
      eval();
      chk("lu_stall", {31'd0, stall}, 32'd1);
      tick();
      eval();
      chk("lu_bubble_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("lu_stall_one_cycle", {31'd0, stall}, 32'd0);
      tick();
      idle(); eval();
      chk("lu_fwd_a_wb", {30'd0, fwd_a}, 32'd1);
      tick();

      // add x5 ; sub x7, x5, x5
      set_in(1'b1, C_ADD, 5'd1, 5'd2, 5'd5, 1'b0);
      eval(); tick();
      set_in(1'b1, C_ADD, 5'd5, 5'd5, 5'd7, 1'b0);
      eval();
      chk("raw_no_stall", {31'd0, stall}, 32'd0);
      tick();
      idle(); eval();
      chk("raw_fwd_ab_mem", {28'd0, fwd_a, fwd_b}, 32'b1010);
      tick();

      // taken branch-with-load in EX while ID holds its consumer
      set_in(1'b1, C_BRLD, 5'd1, 5'd2, 5'd5, 1'b0);
      eval(); tick();
      set_in(1'b1, C_ADD, 5'd5, 5'd0, 5'd8, 1'b1);
      eval();
      chk("flush_wins_flush", {31'd0, flush}, 32'd1);
      chk("flush_wins_stall", {31'd0, stall}, 32'd0);
      tick();
      idle(); eval();
      chk("flush_bubble", {31'd0, ex_valid}, 32'd0);
      tick();

      // lw x0 ; consumer of x0, plus taken on a non-branch
      set_in(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 1'b0);
      eval(); tick();
      set_in(1'b1, C_ADD, 5'd0, 5'd0, 5'd9, 1'b1);
      eval();
      chk("x0_no_stall", {31'd0, stall}, 32'd0);
      chk("taken_nonbranch", {31'd0, flush}, 32'd0);
      tick();
      idle(); eval();
      chk("x0_fwd_mem", {28'd0, fwd_a, fwd_b}, 32'd0);
      tick(); eval();
      chk("x0_fwd_wb", {28'd0, fwd_a, fwd_b}, 32'd0);

      // reset asserted mid-stall, no clock edge in between
      set_in(1'b1, C_LW, 5'd1, 5'd2, 5'd3, 1'b0);
      eval(); tick();
      set_in(1'b1, C_ADD, 5'd3, 5'd1, 5'd4, 1'b0);
      eval();
      #1 rst = 1'b1;
      #1;
      chk("midrun_reset_zero", dut_ex() | dut_mem() | dut_wb() | dut_haz(), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      eval();
      chk("no_stall_after_reset", {31'd0, stall}, 32'd0);
      tick();

      // randomized traffic on a small register set to provoke hazards
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom % 4) != 0, 10'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom % 3) == 0);
         eval();
         tick();
         if (i == 200) begin
            #1 rst = 1'b1;
            #1;
            chk("rand_reset_zero", dut_ex() | dut_mem() | dut_wb(), 32'd0);
            model_reset();
            @(posedge clk);
            #1 rst = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
